scfifo_valid_model: RTL

// Parametrised single-clock FIFO model with per-entry valid-bit shadow tracking, for verification harnesses.

---
 rtl/scfifo_valid_model.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/scfifo_valid_model.sv
// Single-clock FIFO model that stores a shadow valid bit with each entry and
// republishes it as valid / assign shadow outputs for taint-tracking checkers.
module scfifo_valid_model #(
    parameter int    lpm_width       = 8,
    parameter int    lpm_numwords    = 16,
    parameter int    lpm_widthu      = 4,
    parameter string lpm_showahead   = "ON",
    parameter int    almost_full_val = 12
) (
    input  logic                  clock,
    input  logic                  sclr,
    input  logic [lpm_width-1:0]  data,
    input  logic                  valid_data,
    input  logic                  wrreq,
    input  logic                  rdreq,
    output logic [lpm_width-1:0]  q,
    output logic                  valid_q,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic [lpm_widthu:0]   usedw,
    output logic                  overflow_err,
    output logic                  underflow_err,
    output logic                  av_q,
    output logic                  ai_q,
    output logic                  assign_q,
    output logic                  valid_q_q,
    output logic                  av_q_q,
    output logic                  ai_q_q,
    output logic                  assign_q_q
);

    localparam bit                   show_ahead = (lpm_showahead == "ON");
    localparam logic [lpm_widthu:0]  depth_lvl  = lpm_numwords[lpm_widthu:0];
    localparam logic [lpm_widthu:0]  af_lvl     = almost_full_val[lpm_widthu:0];

    logic [lpm_width-1:0]    mem_q [lpm_numwords];
    logic [lpm_width-1:0]    mem_d [lpm_numwords];
    logic [lpm_numwords-1:0] vmem_q, vmem_d;
    logic [lpm_widthu-1:0]   wr_ptr_q, wr_ptr_d;
    logic [lpm_widthu-1:0]   rd_ptr_q, rd_ptr_d;
    logic [lpm_widthu:0]     usedw_q, usedw_d;
    logic                    empty_flag_q, empty_flag_d;
    logic                    full_flag_q, full_flag_d;
    logic                    af_flag_q, af_flag_d;
    logic                    ovf_q, ovf_d;
    logic                    udf_q, udf_d;
    logic [lpm_width-1:0]    q_reg_q, q_reg_d;
    logic                    vreg_q, vreg_d;
    logic                    rdreq_dly_q, rdreq_dly_d;
    logic                    empty_dly_q, empty_dly_d;
    logic                    valid_dly_q, valid_dly_d;
    logic                    av_dly_q, av_dly_d;
    logic                    ai_dly_q, ai_dly_d;
    logic                    assign_dly_q, assign_dly_d;
    logic                    wr_acc, rd_acc;

    // Handshake: a write is taken when wrreq && !full, a read when rdreq && !empty;
    // a request against the blocking flag is dropped and latches its sticky error.
    always_comb begin
        wr_acc       = wrreq & ~full_flag_q;
        rd_acc       = rdreq & ~empty_flag_q;
        mem_d        = mem_q;
        vmem_d       = vmem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        usedw_d      = usedw_q;
        q_reg_d      = q_reg_q;
        vreg_d       = vreg_q;
        if (wr_acc) begin
            mem_d[wr_ptr_q]  = data;
            vmem_d[wr_ptr_q] = valid_data;
            wr_ptr_d         = wr_ptr_q + lpm_widthu'(1);
        end
        if (rd_acc) begin
            q_reg_d  = mem_q[rd_ptr_q];
            vreg_d   = vmem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + lpm_widthu'(1);
        end
        case ({wr_acc, rd_acc})
            2'b10:   usedw_d = usedw_q + (lpm_widthu+1)'(1);
            2'b01:   usedw_d = usedw_q - (lpm_widthu+1)'(1);
            default: usedw_d = usedw_q;
        endcase
        // Flags come from next-state occupancy so they line up with usedw.
        empty_flag_d = (usedw_d == '0);
        full_flag_d  = (usedw_d == depth_lvl);
        af_flag_d    = (usedw_d >= af_lvl);
        ovf_d        = ovf_q | (wrreq & full_flag_q);
        udf_d        = udf_q | (rdreq & empty_flag_q);
        rdreq_dly_d  = rdreq;
        empty_dly_d  = empty_flag_q;
        valid_dly_d  = valid_q;
        av_dly_d     = av_q;
        ai_dly_d     = ai_q;
        assign_dly_d = assign_q;
    end

    always_ff @(posedge clock) begin
        if (sclr) begin
            for (int i = 0; i < lpm_numwords; i++) mem_q[i] <= '0;
            vmem_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            usedw_q      <= '0;
            empty_flag_q <= 1'b1;
            full_flag_q  <= 1'b0;
            af_flag_q    <= 1'b0;
            ovf_q        <= 1'b0;
            udf_q        <= 1'b0;
            q_reg_q      <= '0;
            vreg_q       <= 1'b0;
            rdreq_dly_q  <= 1'b0;
            empty_dly_q  <= 1'b1;
            valid_dly_q  <= 1'b0;
            av_dly_q     <= 1'b0;
            ai_dly_q     <= 1'b1;
            assign_dly_q <= 1'b1;
        end else begin
            mem_q        <= mem_d;
            vmem_q       <= vmem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            usedw_q      <= usedw_d;
            empty_flag_q <= empty_flag_d;
            full_flag_q  <= full_flag_d;
            af_flag_q    <= af_flag_d;
            ovf_q        <= ovf_d;
            udf_q        <= udf_d;
            q_reg_q      <= q_reg_d;
            vreg_q       <= vreg_d;
            rdreq_dly_q  <= rdreq_dly_d;
            empty_dly_q  <= empty_dly_d;
            valid_dly_q  <= valid_dly_d;
            av_dly_q     <= av_dly_d;
            ai_dly_q     <= ai_dly_d;
            assign_dly_q <= assign_dly_d;
        end
    end

    // Legacy mode: valid pulses for the single cycle after an accepted read.
    assign q       = show_ahead ? mem_q[rd_ptr_q] : q_reg_q;
    assign valid_q = show_ahead ? (vmem_q[rd_ptr_q] & ~empty_flag_q)
                                : (vreg_q & rdreq_dly_q & ~empty_dly_q);
    assign av_q    = valid_q;
    assign ai_q    = ~valid_q;
    assign assign_q = av_q | ai_q;

    assign empty         = empty_flag_q;
    assign full          = full_flag_q;
    assign almost_full   = af_flag_q;
    assign usedw         = usedw_q;
    assign overflow_err  = ovf_q;
    assign underflow_err = udf_q;
    assign valid_q_q     = valid_dly_q;
    assign av_q_q        = av_dly_q;
    assign ai_q_q        = ai_dly_q;
    assign assign_q_q    = assign_dly_q;

endmodule
